sdio_response_sequencer: RTL
============================

# sdio_response_sequencer

Sequences the byte stream that `sdio_slave` transmits on a CMD53 read. It buffers bytes received from the host (`read_byte_strobe`/`read_byte`) in a small FIFO. When the slave signals a new response of N bytes, it serves the response handshake byte-by-byte, padding when the FIFO runs dry. It sits in the 200 MHz domain next to `sdio_slave`, replacing ad-hoc response feeding logic in the top level.

## Interface
- `FIFO_DEPTH_LOG2`, 6, FIFO holds 2^FIFO_DEPTH_LOG2 bytes
- `PAD_BYTE`, 8'hFF, byte sent when FIFO is empty (macro off)

- `clock` in 1: system clock (clock200mhz); single clock domain
- `reset` in 1: asynchronous, active-high reset
- `rx_byte_strobe` in 1: one-cycle pulse, push `rx_byte`
- `rx_byte` in 8: byte received from host
- `start_strobe` in 1: one-cycle pulse from `write_data4_strobe`
- `start_count` in 9: response length in bytes (`data4_count`), sampled on `start_strobe`
- `response_data_req` in 1: one-cycle request for the next byte
- `response_start_write` out 1: one-cycle pulse to the slave
- `response_data` out 8: byte to send
- `response_data_strobe` out 1: one-cycle pulse, `response_data` valid
- `response_data_empty` out 1: no more bytes in the current response
- `busy` out 1: high in SERVE
- `fifo_level` out FIFO_DEPTH_LOG2+1: current FIFO occupancy
- `overflow` out 1: sticky; a push was dropped while the FIFO was full

## Operation
- Reset: state IDLE, FIFO empty, `remaining`=0; all outputs 0 (including `response_data`, `response_data_empty`, `overflow`).
- FIFO push on `rx_byte_strobe`:
  - Accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set (cleared only by reset).
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2.
  - `fifo_level` counts 0..2^FIFO_DEPTH_LOG2; a simultaneous push and pop leaves it unchanged.
- IDLE:
  - On `start_strobe` with `start_count`>0: `remaining`<=`start_count`, pulse `response_start_write`, `response_data_empty`<=0, go to SERVE.
  - On `start_strobe` with `start_count`==0: pulse `response_start_write`, `response_data_empty`<=1, stay IDLE.
  - A `response_data_req` in IDLE drives `response_data_empty`<=1 and produces no strobe.
- SERVE, on `response_data_req`:
  - If `remaining`>0: drive the FIFO head (and pop it) or, if the FIFO is empty, drive the fill byte without popping; pulse `response_data_strobe`; `remaining`<=`remaining`-1.
  - If `remaining`==0: `response_data_empty`<=1, go to IDLE.
- `start_strobe` during SERVE is ignored; the current response completes unchanged.
- `remaining` is 9 bits, never decremented below 0. `response_data_empty` deasserts only on an accepted `start_strobe`.

## Timing
- `response_start_write` pulses exactly 1 cycle, in the cycle after `start_strobe`.
- `response_data`/`response_data_strobe` are registered and appear 1 cycle after `response_data_req`. `response_data` holds its value until the next served byte.
- Back-to-back requests (every cycle) are each served with 1-cycle latency; throughput is 1 byte/cycle.
- A pushed byte is poppable starting the cycle after its `rx_byte_strobe`; a same-cycle push into an empty FIFO does not satisfy a pop.
- `reset` asserted mid-response:
  - All outputs clear immediately (asynchronously).
  - The FIFO is emptied and the state returns to IDLE.
  - A pending strobe is not emitted.

## Configuration
- `SDIO_RESP_PATTERN_EN` defined: the fill byte on FIFO empty is `remaining[7:0]+8'h35` (value before decrement), a counting pattern for link debugging; `PAD_BYTE` is unused.
- Undefined: the fill byte is `PAD_BYTE`.
- FIFO behaviour is identical either way.

## Test plan
- Push 0x11,0x22,0x33, then start with count=3, then 4 reqs -> strobes carry 0x11,0x22,0x33; the 4th req sets `response_data_empty`=1; `fifo_level`=0.
- Empty FIFO, count=2, 2 reqs -> bytes 0xFF,0xFF (macro off); with `SDIO_RESP_PATTERN_EN` -> 0x37,0x36.
- Push 65 bytes with FIFO_DEPTH_LOG2=6 -> `fifo_level`=64, `overflow`=1, byte 65 dropped. Then push and pop in the same cycle while full -> level stays 64, with no additional drop.
- Start with count=0 -> `response_start_write` pulses once, `response_data_empty`=1 the next cycle, `busy` stays 0.
- During SERVE (count=5, after 2 bytes) assert second `start_strobe` with count=9 -> ignored; exactly 3 more bytes are served. Then assert `reset` for 1 cycle mid-stream -> all outputs 0, `fifo_level`=0, state IDLE.

Source files
------------

// File: rtl/sdio_response_sequencer_if.sv
// Response handshake between sdio_slave and sdio_response_sequencer, plus the
// host-byte push path that feeds the sequencer's FIFO.
interface sdio_response_sequencer_if;
    logic       rx_byte_strobe;
    logic [7:0] rx_byte;
    logic       start_strobe;
    logic [8:0] start_count;
    logic       response_data_req;
    logic       response_start_write;
    logic [7:0] response_data;
    logic       response_data_strobe;
    logic       response_data_empty;

    modport master (
        output rx_byte_strobe, rx_byte, start_strobe, start_count, response_data_req,
        input  response_start_write, response_data, response_data_strobe, response_data_empty
    );

    modport slave (
        input  rx_byte_strobe, rx_byte, start_strobe, start_count, response_data_req,
        output response_start_write, response_data, response_data_strobe, response_data_empty
    );
endinterface

// File: rtl/sdio_response_sequencer.sv
// Feeds the CMD53 read response byte stream to sdio_slave from a host-byte FIFO.
// Define SDIO_RESP_PATTERN_EN to pad with a counting pattern instead of PAD_BYTE.
module sdio_response_sequencer #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 6,
    parameter logic [7:0]  PAD_BYTE        = 8'hFF
) (
    input  logic                     clock,
    input  logic                     reset,
    sdio_response_sequencer_if.slave bus,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    state_t state, state_next;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   level;
    logic                       fifo_empty, fifo_full;
    logic                       pop, push_ok;
    logic [7:0]                 fill_byte;

    logic [8:0] remaining, remaining_next;
    logic [7:0] data_q, data_next;
    logic       strobe_q, strobe_next;
    logic       start_q, start_next;
    logic       empty_q, empty_next;
    logic       ovf_q;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LEVEL_FULL);
    // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
    assign push_ok    = bus.rx_byte_strobe && (!fifo_full || pop);

`ifdef SDIO_RESP_PATTERN_EN
    assign fill_byte = remaining[7:0] + 8'h35;
`else
    assign fill_byte = PAD_BYTE;
`endif

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        data_next      = data_q;
        strobe_next    = 1'b0;
        start_next     = 1'b0;
        empty_next     = empty_q;
        pop            = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start_strobe) begin
                    start_next = 1'b1;
                    if (bus.start_count != '0) begin
                        remaining_next = bus.start_count;
                        empty_next     = 1'b0;
                        state_next     = SERVE;
                    end else begin
                        empty_next = 1'b1;
                    end
                end else if (bus.response_data_req) begin
                    empty_next = 1'b1;
                end
            end
            SERVE: begin
                if (bus.response_data_req) begin
                    if (remaining != '0) begin
                        strobe_next    = 1'b1;
                        remaining_next = remaining - 1'b1;
                        if (fifo_empty) begin
                            data_next = fill_byte;
                        end else begin
                            data_next = mem[rd_ptr];
                            pop       = 1'b1;
                        end
                    end else begin
                        empty_next = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            data_q    <= '0;
            strobe_q  <= 1'b0;
            start_q   <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            data_q    <= data_next;
            strobe_q  <= strobe_next;
            start_q   <= start_next;
            empty_q   <= empty_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push_ok) begin
                level <= level - 1'b1;
            end
            if (bus.rx_byte_strobe && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the pointers alone define valid contents.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.rx_byte;
        end
    end

    assign bus.response_start_write = start_q;
    assign bus.response_data        = data_q;
    assign bus.response_data_strobe = strobe_q;
    assign bus.response_data_empty  = empty_q;
    assign busy                     = (state == SERVE);
    assign fifo_level               = level;
    assign overflow                 = ovf_q;

endmodule
